// File: rtl/tlatch_sched_pkg.sv
// Purpose : shared types and constants for the T-latch toggle scheduler.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package tlatch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Window counter width; PULSE_W and GAP are limited to 15 so 4 bits suffice.
  localparam int CNT_W  = 4;
  localparam int TCNT_W = 16;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PULSE_W = 2;
  localparam int DEF_GAP     = 1;

endpackage

// File: rtl/tlatch_toggle_sched_rr_pick.sv
// Purpose : combinational round-robin pick, search starts at ptr+1 and wraps.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; valid simply reflects any request being present.
// Ports   : req (per-requester request), ptr (last winner),
//           winner (chosen index), valid (some request present).
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  // Two ascending passes: first the indices above ptr, then the wrap-around
  // part 0..ptr. The first hit wins, which gives rotating priority.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && (i > int'(ptr))) begin
        valid  = 1'b1;
        winner = PTR_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && (i <= int'(ptr))) begin
        valid  = 1'b1;
        winner = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlatch_toggle_sched.sv
// Purpose : round-robin share of one T-latch bank; pulse enable, then guard gap.
// Latency : grant/enable 1 cycle after IDLE sample; q/toggle_cnt PULSE_W cycles later.
// Backpressure: req held by requester until gnt; sampled only in IDLE.
// Ports   : clk, rst (async active-high), req/mask in; gnt (1-cycle one-hot),
//           en_out/t_out (bank drive), q (bank shadow), busy, toggle_cnt out.
module tlatch_toggle_sched
  import tlatch_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP     = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  en_out,
  output logic [WIDTH-1:0]      t_out,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [TCNT_W-1:0]     toggle_cnt
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  // Guard reload is only used when GAP>0; clamp so GAP=0 never underflows.
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_q;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [WIDTH-1:0]   sel_mask;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        sel_mask = mask[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= PTR_RST;
      win_q      <= '0;
      gnt        <= '0;
      en_out     <= 1'b0;
      t_out      <= '0;
      q          <= '0;
      busy       <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt    <= NREQ'(1) << pick_idx;
            t_out  <= sel_mask;
            en_out <= 1'b1;
            cnt    <= PULSE_LD;
            win_q  <= pick_idx;
            busy   <= 1'b1;
            state  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            // Window closes: commit the toggle to the shadow and advance ptr.
            en_out     <= 1'b0;
            q          <= q ^ t_out;
            toggle_cnt <= toggle_cnt + TCNT_W'(1);
            ptr        <= win_q;
            if (GAP > 0) begin
              cnt   <= GAP_LD;
              state <= ST_GUARD;
            end else begin
              t_out <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GUARD: begin
          // t_out is held through the guard so it never moves near an enable.
          if (cnt == '0) begin
            t_out <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          en_out <= 1'b0;
          t_out  <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlatch_toggle_sched.sv
// Purpose : randomized + directed bench for tlatch_toggle_sched against a
//           grant-timeline reference model; a second GAP=0 instance is probed.
module tb_tlatch_toggle_sched;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int PULSE_W = 2;
  localparam int GAP     = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] mask = '0;
  logic [NREQ-1:0]       gnt;
  logic                  en_out;
  logic [WIDTH-1:0]      t_out;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [15:0]           toggle_cnt;

  logic [NREQ-1:0]       req0 = '0;
  logic [NREQ*WIDTH-1:0] mask0 = '0;
  logic [NREQ-1:0]       gnt0;
  logic                  en0;
  logic [WIDTH-1:0]      t0;
  logic [WIDTH-1:0]      q0;
  logic                  busy0;
  logic [15:0]           tc0;

  always #5 clk = ~clk;

  tlatch_toggle_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .PULSE_W(PULSE_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .gnt(gnt), .en_out(en_out),
    .t_out(t_out), .q(q), .busy(busy), .toggle_cnt(toggle_cnt)
  );

  tlatch_toggle_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .PULSE_W(2), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .mask(mask0), .gnt(gnt0), .en_out(en0),
    .t_out(t0), .q(q0), .busy(busy0), .toggle_cnt(tc0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: a list of grant events on an edge timeline.
  int              cyc = 0;
  int              idle_edge;
  int              g_edge;
  int              g_win;
  logic [WIDTH-1:0] g_mask;
  logic [WIDTH-1:0] mq;
  int              mcnt;
  int              mptr;
  int              obs_cyc[$];
  int              obs_idx[$];

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    g_edge = -1000;
    g_win  = 0;
    g_mask = '0;
    mq     = '0;
    mcnt   = 0;
    mptr   = NREQ - 1;
  endtask

  task automatic compare_all(input string tag);
    int d;
    logic [NREQ-1:0]  e_gnt;
    logic             e_en;
    logic [WIDTH-1:0] e_t;
    logic             e_busy;
    d      = cyc - g_edge;
    e_gnt  = (d == 0) ? NREQ'(1) << g_win : '0;
    e_en   = (d >= 0) && (d < PULSE_W);
    e_busy = (d >= 0) && (d < PULSE_W + GAP);
    e_t    = e_busy ? g_mask : '0;
    check({tag, ".gnt"},  32'(gnt), 32'(e_gnt));
    check({tag, ".en"},   32'(en_out), 32'(e_en));
    check({tag, ".t"},    32'(t_out), 32'(e_t));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".q"},    32'(q), 32'(mq));
    check({tag, ".tcnt"}, 32'(toggle_cnt), 32'(mcnt));
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        obs_cyc.push_back(cyc);
        obs_idx.push_back(i);
      end
    end
  endtask

  // One clock edge: advance the model with the inputs sampled at that edge,
  // then compare outputs 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
      idle_edge = cyc + 1;
    end else begin
      if (cyc - g_edge == PULSE_W) begin
        mq   = mq ^ g_mask;
        mcnt = (mcnt + 1) % 65536;
        mptr = g_win;
      end
      if (cyc == idle_edge) begin
        if (req != '0) begin
          g_win     = rr_winner(req, mptr);
          g_mask    = mask[g_win*WIDTH +: WIDTH];
          g_edge    = cyc;
          idle_edge = cyc + 1 + PULSE_W + GAP;
        end else begin
          idle_edge = cyc + 1;
        end
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    step({tag, ".held"});
    rst = 1'b0;
    obs_cyc.delete();
    obs_idx.delete();
  endtask

  initial begin
    model_reset();
    idle_edge = 0;
    #1;
    compare_all("reset");
    step("reset_edge");
    rst = 1'b0;

    // Reset in the middle of a pulse: nothing gets committed.
    req = 4'b0001;
    mask[7:0] = 8'hFF;
    step("rmp_grant");
    req = '0;
    step("rmp_pulse1");
    do_reset("rmp");
    for (int i = 0; i < 6; i++) step("rmp_after");
    check("rmp_q_final", 32'(q), 32'h0);
    check("rmp_tcnt_final", 32'(toggle_cnt), 32'h0);

    // Single requester held for two grants.
    do_reset("single_rst");
    req = 4'b0001;
    mask[7:0] = 8'h0F;
    for (int i = 0; i < 12 && obs_cyc.size() < 2; i++) step("single");
    req = '0;
    for (int i = 0; i < 6; i++) step("single_tail");
    check("single_ngrants", 32'(obs_cyc.size()), 32'd2);
    if (obs_cyc.size() == 2)
      check("single_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd4);
    check("single_q", 32'(q), 32'h00);
    check("single_tcnt", 32'(toggle_cnt), 32'd2);

    // Fairness: all four held.
    do_reset("fair_rst");
    req  = 4'b1111;
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    for (int i = 0; i < 30 && obs_cyc.size() < 5; i++) step("fair");
    req = '0;
    for (int i = 0; i < 6; i++) step("fair_tail");
    check("fair_ngrants", 32'(obs_cyc.size()), 32'd5);
    for (int i = 0; i < obs_idx.size() && i < 5; i++) begin
      check($sformatf("fair_order%0d", i), 32'(obs_idx[i]), 32'(i % 4));
      if (i > 0) check($sformatf("fair_gap%0d", i), 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd4);
    end
    check("fair_q", 32'(q), 32'h0E);
    check("fair_tcnt", 32'(toggle_cnt), 32'd5);

    // Request timing relative to PULSE/GUARD.
    do_reset("tim_rst");
    mask = {8'h80, 8'h40, 8'h20, 8'h10};
    req  = 4'b0010;
    step("tim_grant1");
    req = 4'b0100;
    step("tim_pulse");
    step("tim_to_guard");
    req = 4'b1100;
    step("tim_to_idle");
    req = 4'b0100;
    step("tim_grant2");
    req = '0;
    for (int i = 0; i < 8; i++) step("tim_tail");
    check("tim_ngrants", 32'(obs_cyc.size()), 32'd2);
    if (obs_cyc.size() == 2) begin
      check("tim_first", 32'(obs_idx[0]), 32'd1);
      check("tim_second", 32'(obs_idx[1]), 32'd2);
      check("tim_second_at", 32'(obs_cyc[1] - obs_cyc[0]), 32'd4);
    end

    // Zero mask still granted and counted.
    do_reset("zero_rst");
    mask = '0;
    req  = 4'b0010;
    step("zero_grant");
    req = '0;
    for (int i = 0; i < 6; i++) step("zero_tail");
    check("zero_ngrants", 32'(obs_cyc.size()), 32'd1);
    check("zero_q", 32'(q), 32'h0);
    check("zero_tcnt", 32'(toggle_cnt), 32'd1);

    // GAP=0 instance: exactly one low IDLE cycle between pulses, t_out 0 there.
    begin
      bit started = 0;
      int low_run = 0;
      int high_run = 0;
      int n_low = 0;
      req0  = 4'b0011;
      mask0 = {8'h00, 8'h00, 8'h05, 8'h0A};
      for (int i = 0; i < 24; i++) begin
        step("gap0_main");
        if (en0) begin
          if (started && low_run > 0) begin
            check("gap0_low_len", 32'(low_run), 32'd1);
            n_low++;
          end
          low_run = 0;
          high_run++;
          started = 1;
        end else if (started) begin
          if (high_run > 0) check("gap0_high_len", 32'(high_run), 32'd2);
          high_run = 0;
          low_run++;
          check("gap0_t_idle", 32'(t0), 32'h0);
        end
      end
      check("gap0_saw_gaps", 32'(n_low > 3), 32'd1);
      req0 = '0;
    end

    // Randomized traffic with occasional resets.
    do_reset("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd");
      end
      if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) mask = {$urandom, $urandom};
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlatch_toggle_sched.md
# tlatch_toggle_sched

- Round-robin scheduler that shares one WIDTH-bit bank of T (toggle) latches among NREQ requesters.
- Each granted request drives the bank's T inputs with the requester's mask and holds the latch enable high for a fixed transparency window.
- A guard gap follows each window so the level-sensitive latches never see back-to-back enables.
- The block keeps a shadow copy of the bank state and a toggle counter for software and debug.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, latch bank width
- PULSE_W, 2, enable-high cycles per grant (1..15)
- GAP, 1, enable-low guard cycles after each pulse (0..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request per requester; held until its gnt is seen
- mask  in  NREQ*WIDTH  toggle mask; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, high exactly one cycle
- en_out  out  1  latch bank enable
- t_out  out  WIDTH  latch bank T inputs
- q  out  WIDTH  shadow of bank state
- busy  out  1  high when state is not IDLE
- toggle_cnt  out  16  completed toggle operations, wraps 0xFFFF to 0

## Operation
- FSM states are IDLE, PULSE and GUARD.
- **IDLE:** req is sampled only here. If req is nonzero, pick the winner round-robin, searching from ptr+1 mod NREQ upward. Then at the edge:
  - gnt goes to one-hot(winner)
  - t_out takes mask[winner]
  - en_out goes to 1
  - cnt loads PULSE_W-1
  - state moves to PULSE
- **PULSE:** gnt returns to 0. en_out and t_out are held. cnt decrements each cycle. On the edge where cnt==0:
  - en_out goes to 0
  - q takes q ^ t_out
  - toggle_cnt increments
  - ptr takes winner
  - If GAP>0, cnt loads GAP-1 and state moves to GUARD.
  - Otherwise t_out clears to 0 and state moves to IDLE.
- **GUARD:** en_out stays 0 and t_out is held. When cnt==0, t_out clears to 0 and state moves to IDLE.
- **Zero mask:** still granted and still counted. q is unchanged.
- **Requests outside IDLE:** requests asserted or dropped during PULSE/GUARD have no effect. A req dropped before the next IDLE sample is never granted.
- **Requester handshake:** after seeing gnt, a requester deasserts or changes req/mask in the following cycle. A req still high in the next IDLE is treated as a new request.
- **Reset values:**
  - Asserting rst at any time forces state to IDLE, with gnt=0, en_out=0, t_out=0, q=0, toggle_cnt=0, busy=0, cnt=0.
  - ptr resets to NREQ-1, so the first search starts at requester 0.
  - A pulse interrupted by rst does not update q or toggle_cnt.

## Timing
- Request at IDLE edge k: gnt and en_out are high from cycle k+1. gnt lasts 1 cycle; en_out lasts PULSE_W cycles.
- q and toggle_cnt update at edge k+PULSE_W, so they are visible from cycle k+PULSE_W+1.
- Grant-to-grant minimum period is 1+PULSE_W+GAP cycles, because the IDLE cycle is mandatory.
- t_out is stable for the whole en_out window and the GUARD window. It is never changed while en_out=1.
- All outputs are registered; there is no combinational path from req to any output.
- busy is high from the cycle gnt rises through the last GUARD cycle.

## Structure
- Package tlatch_sched_pkg holds:
  - the FSM state enum (IDLE, PULSE, GUARD)
  - the cnt width constant (4 bits)
  - the toggle_cnt width constant (16)
  - default parameter constants
- Sub-module rr_pick is combinational only. Inputs are req[NREQ-1:0] and ptr; outputs are winner index and valid.

## Test plan
- **Reset mid-pulse:** req[0]=1 with mask 0xFF, rst at cycle 2 of PULSE → all outputs 0 immediately; q stays 0 and toggle_cnt stays 0 after rst releases.
- **Single requester** (PULSE_W=2, GAP=1): req[0] with mask 0x0F held → gnt=0001 for 1 cycle, en_out high 2 cycles, then q=0x0F and toggle_cnt=1. A second grant 4 cycles later gives q=0x00 and toggle_cnt=2.
- **Fairness:** all four req held, masks 0x01, 0x02, 0x04, 0x08 → grant order 0,1,2,3,0 spaced 4 cycles apart. After four grants q=0x0F.
- **Timing of requests:** req[2] raised during PULSE of requester 1 is granted only after GUARD ends. req[3] pulsed only during GUARD is never granted.
- **Zero mask:** req[1] with mask 0x00 → gnt[1] and en_out pulse still occur, q is unchanged, toggle_cnt increments.
- **GAP=0 configuration:** two requesters held → en_out low for exactly 1 cycle (the IDLE cycle) between pulses, and t_out is 0 in that cycle.
